// File: rtl/shift_unit32.sv
// -----------------------------------------------------------------------------
// shift_unit32
//
// Multi-cycle 32-bit shift/rotate execution unit. One left shifter serves
// SLL, SRL, SRA and ROR. Right-direction operations bit-reverse the operand on
// entry, shift left with the appropriate fill bit, and reverse back on exit.
//
// Ports:
//   clk      in   1   single clock, all state updates on the rising edge
//   reset    in   1   synchronous, active-high reset (aborts any operation)
//   start    in   1   request, only sampled while idle
//   op       in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in  in   32  operand, sampled with start
//   shamt    in   5   shift amount 0..31, sampled with start
//   busy     out  1   high from the accepting edge until done
//   done     out  1   one-cycle pulse, result valid
//   result   out  32  last completed result, held until the next done
//
// Build option:
//   SHIFT_UNIT32_FAST_EN  when defined, the SHIFT state moves 4 bit positions
//                         per edge while at least 4 remain, then 1 per edge.
//                         Results are identical; only latency changes.
// -----------------------------------------------------------------------------
module shift_unit32 #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
`ifdef SHIFT_UNIT32_FAST_EN
    localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   work_reg, work_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic               rev_flag_reg, rev_flag_next;
    logic [1:0]         fill_mode_reg, fill_mode_next;
    logic               sign_reg, sign_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [WIDTH-1:0]   result_reg, result_next;

    // Bit-reversed views of the incoming operand and of the working register.
    logic [WIDTH-1:0]   data_rev;
    logic [WIDTH-1:0]   work_rev;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign data_rev[gi] = data_in[WIDTH-1-gi];
            assign work_rev[gi] = work_reg[WIDTH-1-gi];
        end
    endgenerate

    // Fill bit for a single-position shift. In the reversed domain a right
    // rotate is a left rotate, so ROR recirculates the MSB.
    logic fill1;
    always_comb begin
        fill1 = 1'b0;
        case (fill_mode_reg)
            OP_SRA:  fill1 = sign_reg;
            OP_ROR:  fill1 = work_reg[WIDTH-1];
            default: fill1 = 1'b0;
        endcase
    end

`ifdef SHIFT_UNIT32_FAST_EN
    // Fill nibble for a 4-position shift, built bit by bit so that ROR wraps
    // work[31:28] into [3:0] in order and SRA replicates the sign.
    logic [3:0] fill4;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fill4
            assign fill4[gi] = (fill_mode_reg == OP_SRA) ? sign_reg :
                               (fill_mode_reg == OP_ROR) ? work_reg[WIDTH-4+gi] :
                               1'b0;
        end
    endgenerate
`endif

    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        cnt_next       = cnt_reg;
        rev_flag_next  = rev_flag_reg;
        fill_mode_next = fill_mode_reg;
        sign_next      = sign_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        result_next    = result_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    work_next      = (op != OP_SLL) ? data_rev : data_in;
                    cnt_next       = shamt;
                    rev_flag_next  = (op != OP_SLL);
                    fill_mode_next = op;
                    sign_next      = data_in[WIDTH-1];
                    busy_next      = 1'b1;
                    state_next     = (shamt != CNT_ZERO) ? S_SHIFT : S_FINISH;
                end
            end

            S_SHIFT: begin
`ifdef SHIFT_UNIT32_FAST_EN
                if (cnt_reg >= CNT_FOUR) begin
                    work_next = {work_reg[WIDTH-5:0], fill4};
                    cnt_next  = cnt_reg - CNT_FOUR;
                end else begin
                    work_next = {work_reg[WIDTH-2:0], fill1};
                    cnt_next  = cnt_reg - CNT_ONE;
                end
`else
                work_next = {work_reg[WIDTH-2:0], fill1};
                cnt_next  = cnt_reg - CNT_ONE;
`endif
                // Leave as soon as the remaining count reaches zero.
                if (cnt_next == CNT_ZERO) begin
                    state_next = S_FINISH;
                end
            end

            S_FINISH: begin
                result_next = rev_flag_reg ? work_rev : work_reg;
                done_next   = 1'b1;
                busy_next   = 1'b0;
                state_next  = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            work_reg      <= '0;
            cnt_reg       <= '0;
            rev_flag_reg  <= 1'b0;
            fill_mode_reg <= 2'b00;
            sign_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            cnt_reg       <= cnt_next;
            rev_flag_reg  <= rev_flag_next;
            fill_mode_reg <= fill_mode_next;
            sign_reg      <= sign_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            result_reg    <= result_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_shift_unit32.sv
// -----------------------------------------------------------------------------
// tb_shift_unit32
//
// Scoreboard bench for shift_unit32. The driver pushes the expected result and
// the expected done cycle when it issues an operation; an independent monitor
// pops and compares on every done pulse. Expected values come from the
// directed table constants or from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_shift_unit32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    shift_unit32 dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] exp;
        int          due;
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  s;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: the architectural meaning of each operation.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return dd[31:0];
            end
        endcase
    endfunction

    function automatic int lat(input logic [4:0] s);
`ifdef SHIFT_UNIT32_FAST_EN
        return int'(s) / 4 + int'(s) % 4 + 1;
`else
        return int'(s) + 1;
`endif
    endfunction

    // ---------------- monitor ----------------
    bit          mon_en = 1'b0;
    logic        rst_seen = 1'b0;
    logic [31:0] last_result = '0;
    exp_t        e_mon;

    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done === 1'b1) begin
                chk("busy_with_done", {63'd0, busy}, 64'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got result %h, required no done pulse (cycle %0d)", result, cyc);
                end else begin
                    e_mon = sb.pop_front();
                    chk("result", {32'd0, result}, {32'd0, e_mon.exp});
                    chk("latency", 64'(cyc), 64'(e_mon.due));
                    $display("txn op=%0d d=%h s=%0d -> result=%h exp=%h at cycle %0d (due %0d)",
                             e_mon.op, e_mon.d, e_mon.s, result, e_mon.exp, cyc, e_mon.due);
                end
            end else begin
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    e_mon = sb.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_timeout: got no done by cycle %0d, required done at cycle %0d", cyc, e_mon.due);
                end
                if (rst_seen !== 1'b1) begin
                    chk("result_hold", {32'd0, result}, {32'd0, last_result});
                end
            end
        end
        last_result = result;
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp, input bit expect_done);
        int w;
        exp_t e;
        w = 0;
        while (busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: got busy still high after %0d cycles, required idle", w);
        end
        op      = o;
        data_in = d;
        shamt   = s;
        start   = 1'b1;
        if (expect_done) begin
            e.exp = exp;
            e.due = cyc + 1 + lat(s);
            e.op  = o;
            e.d   = d;
            e.s   = s;
            sb.push_back(e);
        end
        @(negedge clk);
        start   = 1'b0;
        data_in = $urandom;
        shamt   = 5'($urandom);
        op      = 2'($urandom);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    localparam int ND = 11;
    logic [1:0]  d_op  [ND] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10};
    logic [31:0] d_dat [ND] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF000_0000, 32'h7000_0000,
                                32'h8000_0000, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001,
                                32'h8000_0000};
    logic [4:0]  d_sh  [ND] = '{5'd4, 5'd31, 5'd8, 5'd4, 5'd4, 5'd31, 5'd1, 5'd0, 5'd16, 5'd31, 5'd5};
    logic [31:0] d_exp [ND] = '{32'h0000_0010, 32'h0000_0001, 32'h00FF_FFFF, 32'hFF00_0000, 32'h0700_0000,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h5678_1234, 32'h8000_0000,
                                32'hFC00_0000};

    initial begin
        logic [1:0]  ro;
        logic [31:0] rd;
        logic [4:0]  rs;
        int          w;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy",   {63'd0, busy},   64'd0);
        chk("reset_done",   {63'd0, done},   64'd0);
        chk("reset_result", {32'd0, result}, 64'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed vectors, issued back to back (each lands in the previous done cycle).
        for (int i = 0; i < ND; i++) begin
            issue(d_op[i], d_dat[i], d_sh[i], d_exp[i], 1'b1);
        end

        // start while busy must be ignored; the original operand's result returns.
        issue(2'b10, 32'hF000_0000, 5'd10, 32'hFFFC_0000, 1'b1);
        op      = 2'b00;
        data_in = 32'h0000_1234;
        shamt   = 5'd0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;

        // Abort: reset sampled on the third edge after accept.
        issue(2'b00, 32'h0000_ABCD, 5'd10, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",   {63'd0, busy},   64'd0);
        chk("abort_done",   {63'd0, done},   64'd0);
        chk("abort_result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rd = $urandom;
            case ($urandom_range(0, 7))
                0:       rs = 5'd0;
                1:       rs = 5'd31;
                default: rs = 5'($urandom_range(0, 31));
            endcase
            issue(ro, rd, rs, model(ro, rd, rs), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d outstanding, required 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
